// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants, tables, types and state encoding
// Optional macro CORDIC_VECTORING_GAIN_COMP_EN adds the gain-compensation state.
package cordic_pkg;

  localparam int N_FRAC          = 7;
  localparam int W               = N_FRAC + 3;
  localparam int ITERATIONS      = 6;
  localparam int BW_SHIFT_VECTOR = 3;

  typedef logic signed [W-1:0]       dp_t;
  typedef logic signed [N_FRAC:0]    ang_t;
  typedef logic [BW_SHIFT_VECTOR-1:0] shift_t;

  // Angles in units of pi/2^N_FRAC, so +pi/2 is 64
  localparam ang_t HALF_PI = 8'sd64;
  localparam ang_t ANGLE_TABLE [ITERATIONS] = '{8'sd32, 8'sd18, 8'sd9, 8'sd5, 8'sd2, 8'sd1};
  localparam shift_t SHIFT_TABLE [ITERATIONS] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_CALC = 3'd2,
`ifdef CORDIC_VECTORING_GAIN_COMP_EN
    ST_COMP = 3'd3,
`endif
    ST_DONE = 3'd4
  } state_t;

  function automatic dp_t sext(input ang_t v);
    return {{(W-N_FRAC-1){v[N_FRAC]}}, v};
  endfunction

endpackage

// File: rtl/cordic_vectoring_iterative_if.sv
// rtl/cordic_vectoring_iterative_if.sv - sample-in / polar-out handshake bundle
interface cordic_vectoring_iterative_if;
  import cordic_pkg::*;

  ang_t x_i;
  ang_t y_i;
  logic data_in_valid_strobe_i;
  logic ready_o;
  dp_t  mag_o;
  ang_t z_o;
  logic data_out_valid_strobe_o;

  modport master (
    output x_i, y_i, data_in_valid_strobe_i,
    input  ready_o, mag_o, z_o, data_out_valid_strobe_o
  );

  modport slave (
    input  x_i, y_i, data_in_valid_strobe_i,
    output ready_o, mag_o, z_o, data_out_valid_strobe_o
  );

endinterface

// File: rtl/cordic_vectoring_slice.sv
// rtl/cordic_vectoring_slice.sv - one combinational vectoring micro-rotation
module cordic_vectoring_slice
  import cordic_pkg::*;
(
  input  dp_t    x,
  input  dp_t    y,
  input  ang_t   z,
  input  shift_t shift,
  input  ang_t   angle,
  output dp_t    x_next,
  output dp_t    y_next,
  output ang_t   z_next
);

  dp_t  x_sh;
  dp_t  y_sh;
  logic y_neg;

  assign x_sh  = x >>> shift;
  assign y_sh  = y >>> shift;
  assign y_neg = y[W-1];

  // Rotate against the sign of y so y converges to zero
  assign x_next = y_neg ? x - y_sh  : x + y_sh;
  assign y_next = y_neg ? y + x_sh  : y - x_sh;
  assign z_next = y_neg ? z - angle : z + angle;

endmodule

// File: rtl/cordic_vectoring_iterative.sv
// rtl/cordic_vectoring_iterative.sv - iterative vectoring CORDIC, (x,y) to magnitude/phase
// Define CORDIC_VECTORING_GAIN_COMP_EN to scale the magnitude by ~0.609 (adds one cycle).
module cordic_vectoring_iterative
  import cordic_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  cordic_vectoring_iterative_if.slave bus
);

  state_t state_q;
  state_t state_d;
  dp_t    x_q;
  dp_t    y_q;
  ang_t   z_q;
  dp_t    x_next;
  dp_t    y_next;
  ang_t   z_next;
  dp_t    mag_q;
  ang_t   z_out_q;
  logic   valid_q;
  shift_t cnt_q;
  logic   ready;
  logic   start;
  logic   last_iter;

  cordic_vectoring_slice u_slice (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .shift  (SHIFT_TABLE[cnt_q]),
    .angle  (ANGLE_TABLE[cnt_q]),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PRE;
      ST_PRE:  state_d = ST_CALC;
`ifdef CORDIC_VECTORING_GAIN_COMP_EN
      ST_CALC: if (last_iter) state_d = ST_COMP;
      ST_COMP: state_d = ST_DONE;
`else
      ST_CALC: if (last_iter) state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == ST_IDLE);
    start     = ready && bus.data_in_valid_strobe_i;
    last_iter = (cnt_q == shift_t'(ITERATIONS - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      mag_q   <= '0;
      z_out_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            x_q <= sext(bus.x_i);
            y_q <= sext(bus.y_i);
            z_q <= '0;
          end
        end
        ST_PRE: begin
          cnt_q <= '0;
          // Fold the left half-plane into the right so the iterations converge
          if (x_q[W-1]) begin
            if (!y_q[W-1]) begin
              x_q <= y_q;
              y_q <= -x_q;
              z_q <= HALF_PI;
            end else begin
              x_q <= -y_q;
              y_q <= x_q;
              z_q <= -HALF_PI;
            end
          end
        end
        ST_CALC: begin
          x_q <= x_next;
          y_q <= y_next;
          z_q <= z_next;
          if (!last_iter) cnt_q <= cnt_q + shift_t'(1);
        end
`ifdef CORDIC_VECTORING_GAIN_COMP_EN
        ST_COMP: begin
          x_q <= (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6);
        end
`endif
        ST_DONE: begin
          mag_q   <= x_q;
          z_out_q <= z_q;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o                 = ready;
  assign bus.mag_o                   = mag_q;
  assign bus.z_o                     = z_out_q;
  assign bus.data_out_valid_strobe_o = valid_q;

endmodule

// File: tb/tb_cordic_vectoring_iterative.sv
// tb/tb_cordic_vectoring_iterative.sv - scoreboard bench for cordic_vectoring_iterative
module tb_cordic_vectoring_iterative;
  import cordic_pkg::*;

`ifdef CORDIC_VECTORING_GAIN_COMP_EN
  localparam int  LAT  = 9;
  localparam real GAIN = 1.0;
`else
  localparam int  LAT  = 8;
  localparam real GAIN = 1.6468;
`endif

  typedef struct {
    int               exp_mag;
    logic signed [7:0] exp_z;
    int               start;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_vectoring_iterative_if bus ();

  cordic_vectoring_iterative dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  exp_t sb[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   n_valid = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  exp_t              mon_e;
  int                mon_dm;
  logic signed [7:0] mon_dz;

  always @(negedge clk) begin
    if (bus.data_out_valid_strobe_o === 1'b1) begin
      n_valid++;
      checks++;
      if (prev_valid === 1'b1) begin
        errors++;
        $display("FAIL valid_width: strobe high two cycles in a row at cycle %0d, required single cycle", cyc);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: result strobe at cycle %0d with nothing outstanding", cyc);
      end else begin
        mon_e  = sb.pop_front();
        mon_dm = int'(bus.mag_o) - mon_e.exp_mag;
        mon_dz = bus.z_o - mon_e.exp_z;
        checks += 3;
        if (mon_dm > 3 || mon_dm < -3) begin
          errors++;
          $display("FAIL mag: got %0d, required %0d +/-3", bus.mag_o, mon_e.exp_mag);
        end
        if (mon_dz > 2 || mon_dz < -2) begin
          errors++;
          $display("FAIL phase: got %0d, required %0d +/-2 (circular)", bus.z_o, mon_e.exp_z);
        end
        if (cyc - mon_e.start !== LAT) begin
          errors++;
          $display("FAIL latency: got %0d edges, required %0d", cyc - mon_e.start, LAT);
        end
      end
    end
    prev_valid = bus.data_out_valid_strobe_o;
  end

  task automatic drive(input int x, input int y, input bit push);
    exp_t e;
    real  a;
    int   zi;
    @(negedge clk);
    bus.x_i = x[7:0];
    bus.y_i = y[7:0];
    bus.data_in_valid_strobe_i = 1'b1;
    if (push) begin
      a  = $atan2(real'(y), real'(x)) * 128.0 / 3.14159265358979;
      zi = $rtoi(a + ((a >= 0.0) ? 0.5 : -0.5));
      e.exp_z   = zi[7:0];
      e.exp_mag = $rtoi(GAIN * $sqrt(real'(x * x + y * y)) + 0.5);
      e.start   = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.data_in_valid_strobe_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", bus.ready_o); end
    if (bus.mag_o !== '0) begin errors++; $display("FAIL reset_mag: got %0d, required 0", bus.mag_o); end
    if (bus.z_o !== '0) begin errors++; $display("FAIL reset_z: got %0d, required 0", bus.z_o); end
    if (bus.data_out_valid_strobe_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b, required 0", bus.data_out_valid_strobe_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    int vx [5] = '{64, 64, 0, -128, -64};
    int vy [5] = '{0, 64, -64, -128, 0};
    for (int v = 0; v < 5; v++) begin
      drive(vx[v], vy[v], 1'b1);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL vector_timeout: (%0d,%0d) produced no result, %0d outstanding", vx[v], vy[v], sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic test_back_to_back();
    int  base;
    bit  seen;
    base = n_valid;
    drive(64, 64, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b, required 0", bus.ready_o); end
    drive(-128, -128, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.data_out_valid_strobe_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_timeout: got no valid, required one within 20 cycles"); end
    checks++;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL valid_cycle_ready: got %b, required 1", bus.ready_o); end
    drive(0, -64, 1'b1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    repeat (12) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_drain: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (n_valid - base !== 2) begin
      errors++; $display("FAIL ignored_strobe: got %0d valid strobes, required 2", n_valid - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = n_valid;
    drive(64, 64, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (bus.mag_o !== '0) begin errors++; $display("FAIL abort_mag: got %0d, required 0", bus.mag_o); end
    if (bus.z_o !== '0) begin errors++; $display("FAIL abort_z: got %0d, required 0", bus.z_o); end
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, required 1", bus.ready_o); end
    repeat (15) @(negedge clk);
    checks++;
    if (n_valid !== base) begin
      errors++; $display("FAIL abort_valid: got %0d strobes after abort, required 0", n_valid - base);
    end
  endtask

  task automatic test_reset_with_strobe();
    int base;
    base = n_valid;
    @(negedge clk);
    rst = 1'b1;
    bus.x_i = 8'sd64;
    bus.y_i = 8'sd0;
    bus.data_in_valid_strobe_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.data_in_valid_strobe_i = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rst_strobe_ready: got %b, required 1", bus.ready_o); end
    repeat (12) @(negedge clk);
    checks++;
    if (n_valid !== base) begin
      errors++; $display("FAIL rst_strobe_valid: got %0d strobes, required 0", n_valid - base);
    end
  endtask

  initial begin
    bus.x_i = '0;
    bus.y_i = '0;
    bus.data_in_valid_strobe_i = 1'b0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_reset_with_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
